// File: rtl/pulse_xfer_sched.sv
// Pulse transfer scheduler: collects single-cycle event pulses from four
// requesters, arbitrates round-robin, and drives one stretched pulse at a
// time onto a shared crossing channel, each followed by an enforced idle gap.
// Lost events (re-request while still pending) are flagged in sticky ovf bits.
module pulse_xfer_sched #(
  parameter int NREQ = 4,
  parameter int GAP  = 2
) (
  input  logic            clk1,
  input  logic            rstn,
  input  logic [NREQ-1:0] req_pulse,
  input  logic [3:0]      cfg_len,
  input  logic            ovf_clr,
  output logic            chan_pulse,
  output logic [1:0]      chan_id,
  output logic            busy,
  output logic [NREQ-1:0] pend,
  output logic [NREQ-1:0] ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_SPACE = 2'd2
  } state_t;

  localparam logic [3:0] GAP_L = 4'(GAP);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [3:0]      cnt_r;
  logic [3:0]      cnt_nxt_s;
  logic [3:0]      gap_r;
  logic [3:0]      gap_nxt_s;
  logic [1:0]      rr_ptr_r;
  logic [1:0]      rr_nxt_s;
  logic            grant_s;
  logic [1:0]      win_s;
  logic [NREQ-1:0] clr_s;
  logic [NREQ-1:0] ovf_set_s;
  logic            chan_pulse_nxt_s;
  logic [1:0]      chan_id_nxt_s;
  logic            busy_nxt_s;
  logic [NREQ-1:0] pend_nxt_s;
  logic [NREQ-1:0] ovf_nxt_s;

  // Round-robin pick: first pending index found searching upward from ptr.
  function automatic logic [1:0] rr_pick(input logic [3:0] p, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && p[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        win   = win;
      end
    end
    return win;
  endfunction

  // A zero length request still produces a one-cycle pulse.
  function automatic logic [3:0] eff_len(input logic [3:0] len);
    if (len == 4'd0) begin
      return 4'd1;
    end else begin
      return len;
    end
  endfunction

  // State register together with the length/gap counters and arbitration pointer.
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      state_r  <= S_IDLE;
      cnt_r    <= 4'd0;
      gap_r    <= 4'd0;
      rr_ptr_r <= 2'd0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      gap_r    <= gap_nxt_s;
      rr_ptr_r <= rr_nxt_s;
    end
  end

  // Next-state logic: grant from IDLE, count down the pulse, then the gap.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    gap_nxt_s   = gap_r;
    rr_nxt_s    = rr_ptr_r;
    grant_s     = 1'b0;
    win_s       = rr_pick(pend, rr_ptr_r);
    case (state_r)
      S_IDLE: begin
        if (pend != 4'b0000) begin
          grant_s     = 1'b1;
          state_nxt_s = S_DRIVE;
          cnt_nxt_s   = eff_len(cfg_len);
          rr_nxt_s    = win_s + 2'd1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_DRIVE: begin
        if (cnt_r <= 4'd1) begin
          state_nxt_s = S_SPACE;
          cnt_nxt_s   = 4'd0;
          gap_nxt_s   = GAP_L;
        end else begin
          cnt_nxt_s   = cnt_r - 4'd1;
        end
      end
      S_SPACE: begin
        if (gap_r <= 4'd1) begin
          state_nxt_s = S_IDLE;
          gap_nxt_s   = 4'd0;
        end else begin
          gap_nxt_s   = gap_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = 4'd0;
        gap_nxt_s   = 4'd0;
      end
    endcase
  end

  // Output next values; outputs are registered copies so nothing is combinational to the pins.
  always_comb begin
    chan_pulse_nxt_s = (state_nxt_s == S_DRIVE);
    busy_nxt_s       = (state_nxt_s != S_IDLE);
    if (grant_s) begin
      chan_id_nxt_s = win_s;
      clr_s         = 4'b0001 << win_s;
    end else begin
      chan_id_nxt_s = chan_id;
      clr_s         = 4'b0000;
    end
    // A request landing on the bit being granted re-arms it instead of overflowing.
    ovf_set_s  = req_pulse & pend & ~clr_s;
    pend_nxt_s = (pend & ~clr_s) | req_pulse;
    if (ovf_clr) begin
      ovf_nxt_s = ovf_set_s;
    end else begin
      ovf_nxt_s = ovf | ovf_set_s;
    end
  end

  // Output registers.
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      chan_pulse <= 1'b0;
      chan_id    <= 2'd0;
      busy       <= 1'b0;
      pend       <= 4'b0000;
      ovf        <= 4'b0000;
    end else begin
      chan_pulse <= chan_pulse_nxt_s;
      chan_id    <= chan_id_nxt_s;
      busy       <= busy_nxt_s;
      pend       <= pend_nxt_s;
      ovf        <= ovf_nxt_s;
    end
  end

endmodule

// File: tb/tb_pulse_xfer_sched.sv
// Directed testbench for pulse_xfer_sched (NREQ=4, GAP=2).
module tb_pulse_xfer_sched;

  logic       clk1 = 1'b0;
  logic       rstn;
  logic [3:0] req_pulse;
  logic [3:0] cfg_len;
  logic       ovf_clr;
  logic       chan_pulse;
  logic [1:0] chan_id;
  logic       busy;
  logic [3:0] pend;
  logic [3:0] ovf;

  int n_total = 0;
  int n_pass  = 0;

  pulse_xfer_sched #(.NREQ(4), .GAP(2)) dut (
    .clk1       (clk1),
    .rstn       (rstn),
    .req_pulse  (req_pulse),
    .cfg_len    (cfg_len),
    .ovf_clr    (ovf_clr),
    .chan_pulse (chan_pulse),
    .chan_id    (chan_id),
    .busy       (busy),
    .pend       (pend),
    .ovf        (ovf)
  );

  // Free-running clock.
  always #5 clk1 = ~clk1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk1);
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  initial begin
    rstn      = 1'b0;
    req_pulse = 4'b0000;
    cfg_len   = 4'd0;
    ovf_clr   = 1'b0;
    step(2);
    chk("rst_pulse", 8'(chan_pulse), 8'h00);
    chk("rst_id",    8'(chan_id),    8'h00);
    chk("rst_busy",  8'(busy),       8'h00);
    chk("rst_pend",  8'(pend),       8'h00);
    chk("rst_ovf",   8'(ovf),        8'h00);
    rstn = 1'b1;

    // Fairness: all four at once, 1-cycle pulses, 3 low cycles between.
    cfg_len   = 4'd1;
    req_pulse = 4'b1111;
    step(1);
    req_pulse = 4'b0000;
    chk("fair_pend0", 8'(pend), 8'h0f);
    chk("fair_busy0", 8'(busy), 8'h00);
    step(1);
    for (int k = 0; k < 4; k++) begin
      chk("fair_pulse", 8'(chan_pulse), 8'h01);
      chk("fair_id",    8'(chan_id),    8'(k));
      for (int j = 0; j < 3; j++) begin
        step(1);
        chk("fair_gap", 8'(chan_pulse), 8'h00);
      end
      step(1);
    end
    chk("fair_busy_end", 8'(busy), 8'h00);
    chk("fair_pend_end", 8'(pend), 8'h00);
    chk("fair_ovf_end",  8'(ovf),  8'h00);

    // Single event, cfg_len=3; cfg_len change mid-pulse is ignored.
    cfg_len   = 4'd3;
    req_pulse = 4'b0001;
    step(1);
    req_pulse = 4'b0000;
    chk("single_pend",   8'(pend),       8'h01);
    chk("single_lat1",   8'(chan_pulse), 8'h00);
    step(1);
    chk("single_pulse2", 8'(chan_pulse), 8'h01);
    chk("single_id",     8'(chan_id),    8'h00);
    chk("single_busy2",  8'(busy),       8'h01);
    chk("single_pclr",   8'(pend),       8'h00);
    cfg_len = 4'd7;
    step(1);
    chk("single_pulse3", 8'(chan_pulse), 8'h01);
    step(1);
    chk("single_pulse4", 8'(chan_pulse), 8'h01);
    step(1);
    chk("single_pulse5", 8'(chan_pulse), 8'h00);
    chk("single_busy5",  8'(busy),       8'h01);
    step(1);
    chk("single_busy6",  8'(busy),       8'h01);
    step(1);
    chk("single_busy7",  8'(busy),       8'h00);

    // Round-robin wrap: grant 2, then 0 and 3 together -> 3 before 0.
    cfg_len   = 4'd1;
    req_pulse = 4'b0100;
    step(1);
    req_pulse = 4'b0000;
    chk("wrap_pend2", 8'(pend), 8'h04);
    step(1);
    chk("wrap_id2",   8'(chan_id),    8'h02);
    chk("wrap_p2",    8'(chan_pulse), 8'h01);
    req_pulse = 4'b1001;
    step(1);
    req_pulse = 4'b0000;
    chk("wrap_pend", 8'(pend), 8'h09);
    step(3);
    chk("wrap_p3",   8'(chan_pulse), 8'h01);
    chk("wrap_id3",  8'(chan_id),    8'h03);
    chk("wrap_pnd3", 8'(pend),       8'h01);
    step(4);
    chk("wrap_p0",   8'(chan_pulse), 8'h01);
    chk("wrap_id0",  8'(chan_id),    8'h00);
    chk("wrap_pnd0", 8'(pend),       8'h00);
    step(3);
    chk("wrap_idle", 8'(busy), 8'h00);

    // Overflow on bit 1 while serving 0; clear; set wins over clear.
    cfg_len   = 4'd3;
    req_pulse = 4'b0001;
    step(1);
    req_pulse = 4'b0000;
    step(1);
    chk("ovf_serve0", 8'(chan_pulse), 8'h01);
    req_pulse = 4'b0010;
    step(1);
    chk("ovf_pend1",  8'(pend), 8'h02);
    chk("ovf_none",   8'(ovf),  8'h00);
    step(1);
    chk("ovf_set",    8'(ovf),  8'h02);
    chk("ovf_pend1b", 8'(pend), 8'h02);
    req_pulse = 4'b0000;
    ovf_clr   = 1'b1;
    step(1);
    chk("ovf_clr", 8'(ovf), 8'h00);
    req_pulse = 4'b0010;
    step(1);
    chk("ovf_setwins", 8'(ovf),  8'h02);
    chk("ovf_pend1c",  8'(pend), 8'h02);
    req_pulse = 4'b0000;
    ovf_clr   = 1'b0;
    step(2);
    chk("ovf_grant1", 8'(chan_pulse), 8'h01);
    chk("ovf_id1",    8'(chan_id),    8'h01);
    chk("ovf_pend0",  8'(pend),       8'h00);
    step(3);
    chk("ovf_low1", 8'(chan_pulse), 8'h00);
    step(3);
    chk("ovf_low2",   8'(chan_pulse), 8'h00);
    chk("ovf_idle",   8'(busy),       8'h00);
    chk("ovf_sticky", 8'(ovf),        8'h02);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_clr2", 8'(ovf), 8'h00);

    // cfg_len=0 gives 1-cycle pulse; re-request in own grant cycle re-arms.
    cfg_len   = 4'd0;
    req_pulse = 4'b0100;
    step(1);
    chk("edge_pend", 8'(pend), 8'h04);
    step(1);
    req_pulse = 4'b0000;
    chk("edge_p1",    8'(chan_pulse), 8'h01);
    chk("edge_id",    8'(chan_id),    8'h02);
    chk("edge_rearm", 8'(pend),       8'h04);
    chk("edge_noovf", 8'(ovf),        8'h00);
    step(1);
    chk("edge_len1", 8'(chan_pulse), 8'h00);
    step(3);
    chk("edge_p2",   8'(chan_pulse), 8'h01);
    chk("edge_id2",  8'(chan_id),    8'h02);
    chk("edge_pnd0", 8'(pend),       8'h00);
    step(1);
    chk("edge_len1b", 8'(chan_pulse), 8'h00);
    chk("edge_ovf",   8'(ovf),        8'h00);
    step(2);
    chk("edge_idle", 8'(busy), 8'h00);

    // Reset during the second DRIVE cycle, then latency and rr_ptr after release.
    cfg_len   = 4'd3;
    req_pulse = 4'b0001;
    step(1);
    req_pulse = 4'b0000;
    step(1);
    chk("rmid_p1", 8'(chan_pulse), 8'h01);
    req_pulse = 4'b1000;
    step(1);
    req_pulse = 4'b0000;
    chk("rmid_p2",   8'(chan_pulse), 8'h01);
    chk("rmid_pend", 8'(pend),       8'h08);
    #2;
    rstn = 1'b0;
    #1;
    chk("rmid_async_pulse", 8'(chan_pulse), 8'h00);
    chk("rmid_async_pend",  8'(pend),       8'h00);
    chk("rmid_async_ovf",   8'(ovf),        8'h00);
    chk("rmid_async_busy",  8'(busy),       8'h00);
    step(2);
    rstn      = 1'b1;
    req_pulse = 4'b1001;
    step(1);
    req_pulse = 4'b0000;
    chk("post_pend", 8'(pend),       8'h09);
    chk("post_lat1", 8'(chan_pulse), 8'h00);
    step(1);
    chk("post_pulse", 8'(chan_pulse), 8'h01);
    chk("post_id",    8'(chan_id),    8'h00);
    chk("post_busy",  8'(busy),       8'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
